// File: rtl/ext_arb_pkg.sv
// Shared helpers for the external OBI round-robin arbiter: index width
// helper and the simulation message texts.
package ext_arb_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam string MSG_EMPTY_RVALID = "ext_obi_rr_arbiter: rvalid with no outstanding transaction";
  localparam string MSG_LOCK_DROP    = "ext_obi_rr_arbiter: locked master dropped req before gnt";

endpackage

// File: rtl/obi_pkg.sv
// Minimal OBI request/response types for the external master port.
// Field layout matches the subset used on the x_heep_system external ports.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ext_arb_idx_fifo.sv
// In-order FIFO of granted master indices; the head names the master that
// owns the oldest unanswered transaction.
module ext_arb_idx_fifo #(
  parameter  int DATA_W = 2,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ext_obi_rr_arbiter.sv
// Round-robin arbiter (with one fixed-priority master) sharing the external
// OBI master port; responses are routed back in order through an index FIFO.
module ext_obi_rr_arbiter
  import obi_pkg::*;
  import ext_arb_pkg::*;
#(
  parameter int NMASTER         = 4,
  parameter int PRIO_MASTER     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  master_req_i  [NMASTER],
  output obi_resp_t master_resp_o [NMASTER],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o
);

  localparam int IDX_W = idx_width(NMASTER);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef logic [IDX_W-1:0] idx_t;

  localparam bit   PRIO_EN  = (PRIO_MASTER < NMASTER);
  localparam idx_t PRIO_IDX = idx_t'(PRIO_EN ? PRIO_MASTER : 0);

  idx_t             r_rr_ptr;
  logic             r_lock_valid;
  idx_t             r_lock_idx;

  idx_t             w_sel;
  idx_t             w_cand;
  logic             w_found;
  logic             w_req_valid;
  logic             w_hs;
  logic             w_pop;
  idx_t             w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;

  // A locked selection wins outright so the presented request stays stable until gnt.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_found = 1'b0;
    w_cand  = '0;
    if (r_lock_valid) begin
      w_sel   = r_lock_idx;
      w_found = master_req_i[r_lock_idx].req;
    end else if (PRIO_EN && master_req_i[PRIO_IDX].req) begin
      w_sel   = PRIO_IDX;
      w_found = 1'b1;
    end else begin
      for (int k = 1; k <= NMASTER; k++) begin
        w_cand = idx_t'((int'(r_rr_ptr) + k) % NMASTER);
        if (!w_found && master_req_i[w_cand].req) begin
          w_sel   = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_req_valid = w_found & ~w_fifo_full & rst_ni;
  assign w_hs        = w_req_valid & slave_resp_i.gnt;
  assign w_pop       = slave_resp_i.rvalid & ~w_fifo_empty;
  assign busy_o      = (w_count != '0);

  always_comb begin
    slave_req_o = '0;
    if (w_req_valid) begin
      slave_req_o = master_req_i[w_sel];
    end
  end

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i] = '0;
      if (w_hs && (w_sel == idx_t'(i))) begin
        master_resp_o[i].gnt = 1'b1;
      end
      if (w_pop && (w_head == idx_t'(i))) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr     <= idx_t'(NMASTER - 1);
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
    end else begin
      if (w_hs) begin
        r_rr_ptr     <= w_sel;
        r_lock_valid <= 1'b0;
      end else if (w_req_valid) begin
        r_lock_valid <= 1'b1;
        r_lock_idx   <= w_sel;
      end else if (r_lock_valid && !master_req_i[r_lock_idx].req) begin
        r_lock_valid <= 1'b0;
      end
    end
  end

  ext_arb_idx_fifo #(
    .DATA_W (IDX_W),
    .DEPTH  (MAX_OUTSTANDING)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_data  (w_sel),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // Simulation-only protocol monitors; these never affect the datapath.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(slave_resp_i.rvalid && w_fifo_empty))
        else $warning("%s", MSG_EMPTY_RVALID);
      assert (!(r_lock_valid && !master_req_i[r_lock_idx].req))
        else $warning("%s", MSG_LOCK_DROP);
    end
  end

endmodule

// File: doc/ext_obi_rr_arbiter.md
Name: ext_obi_rr_arbiter

Overview:
Shares the single external OBI master port of the CB-heep cluster between NMASTER requesters: core instr, core data, debug master and peripheral slave. Selection is round-robin, with one fixed high-priority master (debug). The grant is locked while a request waits for gnt. Granted requester indices go into an in-order response-routing FIFO, so that variable-latency rvalid responses return to the correct master. The block sits between the external-core OBI ports of x_heep_system and mochila_top.

Parameters:
NMASTER, 4, number of requesting OBI masters (>=2)
PRIO_MASTER, 2, index of the master that always wins when requesting; set to NMASTER to disable
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (power of 2, >=1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
master_req_i  input  obi_req_t[NMASTER]  requests from masters (req, we, be, addr, wdata)
master_resp_o  output  obi_resp_t[NMASTER]  responses to masters (gnt, rvalid, rdata)
slave_req_o  output  obi_req_t  request to the shared slave
slave_resp_i  input  obi_resp_t  response from the shared slave
busy_o  output  1  at least one transaction outstanding

Behaviour:
- State:
  - rr_ptr: last granted index, reset NMASTER-1, so master 0 is first after reset.
  - lock_valid / lock_idx: reset 0 / 0.
  - Routing FIFO of idx_t entries, depth MAX_OUTSTANDING; count resets to 0.
- Eligibility: master i is eligible when master_req_i[i].req=1 and the FIFO is not full. When the FIFO is full, slave_req_o.req=0 and no gnt is issued. There is no same-cycle bypass from rvalid.
- Selection, combinational:
  - If lock_valid, the selection is lock_idx.
  - Otherwise, if PRIO_MASTER is requesting, the selection is PRIO_MASTER.
  - Otherwise, the first requesting index scanning rr_ptr+1, rr_ptr+2, … modulo NMASTER.
- slave_req_o: the selected master's request fields when eligible. When not eligible, req=0 and the other fields are all zero.
- Grant: master_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req. The gnt of every other master is 0.
- Handshake (slave req & gnt) at clock edge:
  - Push sel into the FIFO.
  - rr_ptr <= sel. This applies to the PRIO_MASTER win as well.
  - lock_valid <= 0.
- Lock: if slave_req_o.req=1 and gnt=0, set lock_valid <= 1 and lock_idx <= sel. This keeps the request stable per OBI until gnt.
  - If the locked master deasserts req (protocol violation), clear the lock next cycle.
  - Raise an assertion in simulation.
- Response routing:
  - slave_resp_i.rvalid pops the FIFO head h.
  - master_resp_o[h].rvalid=1 and master_resp_o[h].rdata=slave_resp_i.rdata.
  - Every other master gets rvalid=0 and rdata=0.
  - The minimum response latency is one cycle after gnt; a same-cycle gnt and rvalid of the same transaction is not supported.
- Simultaneous push and pop: allowed; count is unchanged, and the pointers advance independently with wrap-around modulo MAX_OUTSTANDING.
- rvalid with an empty FIFO: ignored, with no master rvalid asserted. Flag with an assertion.
- busy_o = (count != 0). It is registered-state derived.
- Reset values:
  - All state is cleared asynchronously.
  - While rst_ni=0, every gnt, rvalid and rdata of master_resp_o is 0.
  - While rst_ni=0, slave_req_o is forced to all-zero and busy_o=0.
- Reset mid-operation: outstanding transactions are dropped; late rvalids after reset fall under the empty-FIFO rule.
- Width rules: idx_t = $clog2(NMASTER) bits. The count is $clog2(MAX_OUTSTANDING)+1 bits.

Decomposition:
- Package ext_arb_pkg: the idx_t typedef helper and the assertion message constants. obi_req_t and obi_resp_t come from obi_pkg.
- One sub-module, ext_arb_idx_fifo: a parameterised synchronous FIFO.
  - Ports: push, pop, data in, head out, full, empty, count.
  - Same clock and asynchronous active-low reset as the arbiter.

Test Plan:
1. Masters 0, 1 and 3 request continuously; slave gnt=1 every cycle; rvalid 2 cycles later. Required: grants in order 0,1,3,0,1,3. Each rvalid, with rdata = 0xA0+idx, is routed to the originating master only.
2. Master 1 is held waiting on gnt=0 for 3 cycles while master 2 (PRIO) starts requesting in cycle 1. Required: slave_req_o stays master 1's address 0x1000 until gnt. Master 2 is granted in the next cycle.
3. MAX_OUTSTANDING=4; 4 requests are granted with no rvalid. Required: slave_req_o.req=0 and busy_o=1 while full. One rvalid brings count to 3, and the next request is granted on the following cycle.
4. Same-cycle gnt for master 0 and rvalid for the earlier master 3 entry. Required: master 3 gets rvalid, count is unchanged, and the FIFO pointers wrap correctly across 8+ transactions.
5. Reset asserted with 2 outstanding transactions, then released. Required: all outputs are 0 during reset. A subsequent stray rvalid produces no master rvalid. The first grant after release goes to master 0.
6. rvalid with an empty FIFO at idle. Required: no master rvalid, count stays 0, and the assertion fires.
